// File: rtl/mips_run_controller.sv
// Run sequencer for one mips_cpu_harvard: reset pulse, liveness check, bounded run, v0 compare.
// Optional macro RUN_CTRL_STALL_INJECT_EN adds LFSR-driven clock-enable stalls during RUN.
module mips_run_controller #(
   parameter int RESET_CYCLES   = 2,
   parameter int TIMEOUT_CYCLES = 40,
   parameter int DATA_W         = 32,
   parameter int CNT_W          = $clog2(TIMEOUT_CYCLES + 1)
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [DATA_W-1:0] expected_v0,
   input  logic              cpu_active,
   input  logic [DATA_W-1:0] cpu_register_v0,
   output logic              cpu_reset,
   output logic              cpu_clk_enable,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic              timeout,
   output logic              err_inactive,
   output logic [DATA_W-1:0] result_v0,
   output logic [CNT_W-1:0]  cycle_count
);

   typedef enum logic [2:0] {S_IDLE, S_RESET, S_CHECK, S_RUN, S_DONE} state_t;

   localparam int                RST_W    = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
   localparam logic [RST_W-1:0]  RST_LAST = RST_W'(RESET_CYCLES - 1);
   localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);

   state_t              state, next_state;
   logic [RST_W-1:0]    rst_cnt;
   logic [DATA_W-1:0]   expected_q;
   logic [CNT_W-1:0]    cnt_inc;
   logic                accept, run_tick, run_complete, run_timeout;
   logic                run_en_nx;

   assign accept       = (state == S_IDLE) && start;
   assign run_tick     = (state == S_RUN) && cpu_clk_enable;
   assign cnt_inc      = (cycle_count == CNT_MAX) ? cycle_count : cycle_count + 1'b1;
   // Completion is tested first, so an active-fall on the limit cycle is not a timeout.
   assign run_complete = run_tick && !cpu_active;
   assign run_timeout  = run_tick && cpu_active && (cnt_inc == CNT_MAX);

`ifdef RUN_CTRL_STALL_INJECT_EN
   localparam logic [15:0] LFSR_SEED = 16'hACE1;

   logic [15:0] lfsr, lfsr_nx, lfsr_step;

   assign lfsr_nx   = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
   assign lfsr_step = (state == S_RUN) ? lfsr_nx : lfsr;
   assign run_en_nx = |lfsr_step[1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)              lfsr <= LFSR_SEED;
      else if (accept)         lfsr <= LFSR_SEED;
      else if (state == S_RUN) lfsr <= lfsr_nx;
   end
`else
   assign run_en_nx = 1'b1;
`endif

   always_comb begin
      // NOTE: next_state gets its default before the case so no branch can leave it unassigned (no latch).
      next_state = state;
      case (state)
         S_IDLE:  if (start) next_state = S_RESET;
         S_RESET: if (rst_cnt == RST_LAST) next_state = S_CHECK;
         S_CHECK: next_state = cpu_active ? S_RUN : S_DONE;
         S_RUN:   if (run_complete || run_timeout) next_state = S_DONE;
         S_DONE:  next_state = S_IDLE;
         default: next_state = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= S_IDLE;
         rst_cnt        <= '0;
         expected_q     <= '0;
         cpu_reset      <= 1'b0;
         cpu_clk_enable <= 1'b0;
         busy           <= 1'b0;
         done           <= 1'b0;
         pass           <= 1'b0;
         timeout        <= 1'b0;
         err_inactive   <= 1'b0;
         result_v0      <= '0;
         cycle_count    <= '0;
      end else begin
         // NOTE: non-blocking assignments so every flop here samples pre-edge values, whatever the order.
         state          <= next_state;
         rst_cnt        <= (state == S_RESET) ? rst_cnt + 1'b1 : '0;
         // CPU-facing controls are decoded from next_state so they are clean flop outputs.
         cpu_reset      <= (next_state == S_RESET);
         cpu_clk_enable <= (next_state == S_RESET) || (next_state == S_CHECK) ||
                           ((next_state == S_RUN) && run_en_nx);
         busy           <= (next_state != S_IDLE);
         done           <= (next_state == S_DONE);

         if (accept) begin
            expected_q   <= expected_v0;
            pass         <= 1'b0;
            timeout      <= 1'b0;
            err_inactive <= 1'b0;
            result_v0    <= '0;
            cycle_count  <= '0;
         end

         if ((state == S_CHECK) && !cpu_active) err_inactive <= 1'b1;

         if (run_tick) begin
            cycle_count <= cnt_inc;
            if (run_complete) begin
               result_v0 <= cpu_register_v0;
               pass      <= (cpu_register_v0 == expected_q);
            end else if (run_timeout) begin
               result_v0 <= cpu_register_v0;
               timeout   <= 1'b1;
               pass      <= 1'b0;
            end
         end
      end
   end

endmodule
